// File: rtl/hash_out_serializer_pkg.sv
// Shared definitions for the hash-side datapath and its FSMs.
// Holds the default digest width and the common state encoding.
package hash_out_serializer_pkg;

   // Default digest width in bits
   localparam int HASH_L = 256;

   // State encoding shared by the hash-side FSMs
   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_STREAM = 1'b1;

   typedef enum logic [0:0] {
      ST_IDLE   = S_IDLE,
      ST_STREAM = S_STREAM
   } hash_state_e;

   // Counter width for a given word count; at least one bit
   function automatic int cnt_width(input int nw);
      return (nw > 1) ? $clog2(nw) : 1;
   endfunction

endpackage

// File: rtl/hash_out_serializer_rise_detect.sv
// rise_detect: registered rising-edge detector on a level signal.
// Ports: clk_i, rst_ni (async, active-low), d_i level in, rise_o edge pulse.
module rise_detect (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic rise_o
);

   logic d_q;
   logic armed_q;

   // armed_q keeps the first post-reset sample from being seen as an
   // edge, so a level already high at reset release is ignored.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         d_q     <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         d_q     <= d_i;
         armed_q <= 1'b1;
      end
   end

   assign rise_o = armed_q & d_i & ~d_q;

endmodule

// File: rtl/hash_out_serializer.sv
// Captures a voted digest on the rising edge of hash_ready and streams
// it MSW first as l/W words over valid/ready; flags dropped digests.
// Ports: clk, rst (async active-low), hash_text/hash_ready (capture in),
//   out_data/out_valid/out_last/out_ready (stream), busy,
//   overrun (sticky), clr_overrun (sync clear).
module hash_out_serializer
   import hash_out_serializer_pkg::*;
#(
   parameter int l = HASH_L,
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [l-1:0] hash_text,
   input  logic         hash_ready,
   output logic [W-1:0] out_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         out_last,
   output logic         busy,
   output logic         overrun,
   input  logic         clr_overrun
);

   localparam int NW = l / W;
   localparam int CW = cnt_width(NW);
   localparam logic [CW-1:0] LAST_IDX = CW'(NW - 1);

   hash_state_e  state_q, state_d;
   logic [l-1:0] sr_q, sr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic         ovr_q, ovr_d;
   logic         cap_ev;
   logic         hs;
   logic         is_last;

   rise_detect u_rise (
      .clk_i  (clk),
      .rst_ni (rst),
      .d_i    (hash_ready),
      .rise_o (cap_ev)
   );

   assign out_valid = (state_q == ST_STREAM);
   assign busy      = out_valid;
   assign is_last   = (cnt_q == LAST_IDX);
   assign out_last  = out_valid & is_last;
   // sr is zeroed whenever idle, so out_data reads 0 outside a stream
   assign out_data  = sr_q[l-1 -: W];
   assign overrun   = ovr_q;
   assign hs        = out_valid & out_ready;

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      ovr_d   = ovr_q;

      if (clr_overrun) begin
         ovr_d = 1'b0;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (cap_ev) begin
               sr_d    = hash_text;
               cnt_d   = '0;
               state_d = ST_STREAM;
            end
         end
         ST_STREAM: begin
            if (hs && is_last) begin
               if (cap_ev) begin
                  // back-to-back: no bubble between digests
                  sr_d  = hash_text;
                  cnt_d = '0;
               end else begin
                  sr_d    = '0;
                  cnt_d   = '0;
                  state_d = ST_IDLE;
               end
            end else begin
               if (hs) begin
                  sr_d  = sr_q << W;
                  cnt_d = cnt_q + CW'(1);
               end
               // set after clear so a same-cycle event wins
               if (cap_ev) begin
                  ovr_d = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         ovr_q   <= ovr_d;
      end
   end

endmodule

// File: tb/tb_hash_out_serializer.sv
// Self-checking bench for hash_out_serializer: vector table plus
// hand sequences, with a scoreboard of expected output words.
module tb_hash_out_serializer;

   localparam int L  = 256;
   localparam int W  = 32;
   localparam int NW = L / W;

   logic         clk = 1'b0;
   logic         rst;
   logic [L-1:0] hash_text;
   logic         hash_ready;
   logic [W-1:0] out_data;
   logic         out_valid;
   logic         out_ready;
   logic         out_last;
   logic         busy;
   logic         overrun;
   logic         clr_overrun;

   always #5 clk = ~clk;

   hash_out_serializer #(.l(L), .W(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .hash_text   (hash_text),
      .hash_ready  (hash_ready),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_last    (out_last),
      .busy        (busy),
      .overrun     (overrun),
      .clr_overrun (clr_overrun)
   );

   typedef struct {
      logic [W-1:0] data;
      logic         last;
   } exp_t;

   typedef struct {
      logic [L-1:0] text;
      int           stall_at;
      int           stall_len;
      int           exp_cycles;
   } vec_t;

   exp_t q[$];
   vec_t vecs[4];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                  $time);
      end
   endtask

   function automatic logic [L-1:0] mk(input logic [W-1:0] start,
                                       input logic [W-1:0] step);
      logic [L-1:0] t;
      logic [W-1:0] w;
      t = '0;
      w = start;
      for (int i = 0; i < NW; i++) begin
         t[L-1-W*i -: W] = w;
         w = w + step;
      end
      return t;
   endfunction

   task automatic push_digest(input logic [L-1:0] t);
      exp_t e;
      for (int i = 0; i < NW; i++) begin
         e.data = t[L-1-W*i -: W];
         e.last = (i == NW - 1);
         q.push_back(e);
      end
   endtask

   // One-cycle hash_ready pulse; returns #1 after the capture edge
   task automatic capture(input logic [L-1:0] t);
      @(posedge clk);
      #1;
      hash_text  = t;
      hash_ready = 1'b1;
      push_digest(t);
      @(posedge clk);
      #1;
      hash_ready = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while ((busy || q.size() != 0) && n < budget) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (n >= budget) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: busy=%0b pending=%0d", busy,
                  q.size());
      end
   endtask

   // Scoreboard monitor and hold-stability checker
   logic         stall_q = 1'b0;
   logic [W-1:0] hold_d;
   logic         hold_l;

   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         stall_q = 1'b0;
      end else begin
         if (stall_q) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data", 64'(out_data), 64'(hold_d));
            chk("hold_last", 64'(out_last), 64'(hold_l));
         end
         if (out_valid && out_ready) begin
            stall_q = 1'b0;
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL extra_word: got %h expected none",
                        out_data);
            end else begin
               e = q.pop_front();
               chk("word", 64'(out_data), 64'(e.data));
               chk("last", 64'(out_last), 64'(e.last));
            end
         end else if (out_valid) begin
            stall_q = 1'b1;
            hold_d  = out_data;
            hold_l  = out_last;
         end else begin
            stall_q = 1'b0;
         end
      end
   end

   logic [L-1:0] d1, d2, d3, da;

   initial begin
      int w, s, cyc;
      logic rdy, hs;

      d1 = mk(32'h11111111, 32'h11111111);
      d2 = mk(32'hDEADBEEF, 32'h01010101);
      d3 = mk(32'h00000000, 32'hF0F0F0F1);
      da = mk(32'hAAAAAAAA, 32'h00000000);

      vecs[0] = '{text: d1, stall_at: -1, stall_len: 0, exp_cycles: NW};
      vecs[1] = '{text: d1, stall_at: 2, stall_len: 3,
                  exp_cycles: NW + 3};
      vecs[2] = '{text: d2, stall_at: 0, stall_len: 1,
                  exp_cycles: NW + 1};
      vecs[3] = '{text: d3, stall_at: 7, stall_len: 2,
                  exp_cycles: NW + 2};

      rst         = 1'b0;
      hash_ready  = 1'b0;
      hash_text   = '0;
      out_ready   = 1'b0;
      clr_overrun = 1'b0;

      #12;
      chk("rst_data", 64'(out_data), 64'd0);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_last", 64'(out_last), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_overrun", 64'(overrun), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);

      // Vector table: word order, drain and backpressure patterns
      for (int i = 0; i < 4; i++) begin
         capture(vecs[i].text);
         w   = 0;
         s   = 0;
         cyc = 0;
         while (w < NW && cyc < 200) begin
            rdy = !(w == vecs[i].stall_at && s < vecs[i].stall_len);
            out_ready = rdy;
            @(negedge clk);
            hs = out_valid && rdy;
            @(posedge clk);
            #1;
            cyc++;
            if (hs) w++;
            else if (!rdy) s++;
         end
         chk("vec_cycles", 64'(cyc), 64'(vecs[i].exp_cycles));
         out_ready = 1'b1;
         @(negedge clk);
         chk("vec_valid_drop", 64'(out_valid), 64'd0);
         chk("vec_busy", 64'(busy), 64'd0);
         chk("vec_data_idle", 64'(out_data), 64'd0);
         chk("vec_overrun", 64'(overrun), 64'd0);
         chk("vec_sb_empty", 64'(q.size()), 64'd0);
      end

      // Overrun: second edge while word 4 is on the output
      out_ready = 1'b1;
      capture(d1);
      repeat (3) @(posedge clk);
      #1;
      hash_text  = d3;
      hash_ready = 1'b1;
      @(posedge clk);
      #1;
      hash_ready = 1'b0;
      chk("ovr_set", 64'(overrun), 64'd1);
      wait_idle(40);
      repeat (4) @(posedge clk);
      #1;
      chk("ovr_no_stream", 64'(busy), 64'd0);
      chk("ovr_sticky", 64'(overrun), 64'd1);
      clr_overrun = 1'b1;
      @(posedge clk);
      #1;
      clr_overrun = 1'b0;
      chk("ovr_clear", 64'(overrun), 64'd0);

      // Clear and new overrun in the same cycle: set wins
      capture(d2);
      repeat (3) @(posedge clk);
      #1;
      hash_ready  = 1'b1;
      clr_overrun = 1'b1;
      @(posedge clk);
      #1;
      hash_ready  = 1'b0;
      clr_overrun = 1'b0;
      chk("ovr_set_wins", 64'(overrun), 64'd1);
      wait_idle(40);
      clr_overrun = 1'b1;
      @(posedge clk);
      #1;
      clr_overrun = 1'b0;
      chk("ovr_clear2", 64'(overrun), 64'd0);

      // Back-to-back: edge coincides with the last-word handshake
      capture(d1);
      repeat (7) @(posedge clk);
      #1;
      chk("b2b_at_last", 64'(out_last), 64'd1);
      hash_text  = da;
      hash_ready = 1'b1;
      push_digest(da);
      @(posedge clk);
      #1;
      hash_ready = 1'b0;
      chk("b2b_valid", 64'(out_valid), 64'd1);
      chk("b2b_data", 64'(out_data), 64'hAAAAAAAA);
      chk("b2b_overrun", 64'(overrun), 64'd0);
      wait_idle(40);
      chk("b2b_overrun_end", 64'(overrun), 64'd0);

      // Level held high: exactly one digest
      @(posedge clk);
      #1;
      hash_text  = d2;
      hash_ready = 1'b1;
      push_digest(d2);
      repeat (20) @(posedge clk);
      #1;
      chk("level_busy", 64'(busy), 64'd0);
      chk("level_sb_empty", 64'(q.size()), 64'd0);
      hash_ready = 1'b0;
      wait_idle(40);

      // Reset abort during word 3, level still high after release
      @(posedge clk);
      #1;
      hash_text  = d1;
      hash_ready = 1'b1;
      push_digest(d1);
      @(posedge clk);
      repeat (2) @(posedge clk);
      #1;
      chk("abort_word3", 64'(out_data), 64'h33333333);
      rst = 1'b0;
      q.delete();
      #1;
      chk("abort_data", 64'(out_data), 64'd0);
      chk("abort_valid", 64'(out_valid), 64'd0);
      chk("abort_last", 64'(out_last), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_overrun", 64'(overrun), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("no_cap_after_rst", 64'(busy), 64'd0);
      chk("no_valid_after_rst", 64'(out_valid), 64'd0);
      hash_ready = 1'b0;
      capture(d3);
      chk("recap_valid", 64'(out_valid), 64'd1);
      wait_idle(40);

      chk("final_sb_empty", 64'(q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hash_out_serializer.md
# hash_out_serializer

Downstream stage of the fault-countermeasure hash wrapper. It captures the majority-voted digest `hash_text` when that wrapper raises `ready`. It then streams the digest out as `l/W` words over a valid/ready handshake, most significant word first. The block holds the digest in its own shift register, so the hash core can be restarted as soon as the capture happens. It flags any digest that arrives while a previous one is still draining.

## Interface
- `l`, 256, digest width in bits; must be a multiple of `W`
- `W`, 32, output word width in bits
- `NW`, `l/W` (derived localparam), words per digest
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `hash_text`  in  l  voted digest from the hash wrapper; sampled only on a capture cycle
- `hash_ready`  in  1  hash wrapper `ready`; level signal, may stay high after completion
- `out_data`  out  W  current output word
- `out_valid`  out  1  `out_data` is valid
- `out_ready`  in  1  consumer accepts the word
- `out_last`  out  1  current word is the final word of the digest
- `busy`  out  1  a digest is held or streaming
- `overrun`  out  1  sticky: a digest arrived while busy and was dropped
- `clr_overrun`  in  1  synchronous clear of `overrun`

## Operation
- Edge detect: register `hash_ready` into `rdy_q`; `cap_ev = hash_ready & ~rdy_q`.
- A level that is already high when reset releases does not count as an edge.
- States: IDLE, STREAM.
- IDLE:
  - On `cap_ev`, load the shift register with `hash_text` and set the word counter to 0.
  - Go to STREAM.
- STREAM:
  - `out_data` is `sr[l-1 -: W]`.
  - `out_valid` = 1.
  - `out_last` = (counter == `NW-1`).
- On a handshake (`out_valid & out_ready`) that is not the last word:
  - shift `sr` left by `W`, zero-filling the low bits;
  - increment the counter.
- On the last-word handshake:
  - if `cap_ev` is high in the same cycle, reload `sr` with the new `hash_text`, set the counter to 0 and stay in STREAM (back-to-back, no bubble);
  - otherwise go to IDLE and clear `sr` to 0.
- `cap_ev` in STREAM other than on the last-word handshake: the new digest is dropped, `overrun` is set and streaming of the current digest continues unaltered.
- `overrun` stays set until `clr_overrun` or reset. If `clr_overrun` and a new overrun event occur in the same cycle, set wins.
- `busy` = (state == STREAM).
- The counter is `$clog2(NW)` bits and never wraps past `NW-1`.
- While `out_valid & ~out_ready`, `out_data` and `out_last` must hold stable.

## Timing
- Reset values: `out_data`=0, `out_valid`=0, `out_last`=0, `busy`=0, `overrun`=0, `rdy_q`=0, state IDLE, `sr`=0.
- Reset asserted mid-stream aborts immediately (asynchronous) to those values. The partially streamed digest is lost.
- Capture latency:
  - `hash_ready` rises before clock edge N, so `cap_ev` is high in cycle N.
  - The digest is registered at edge N.
  - `out_valid`=1 with word 0 in the cycle after edge N.
- Throughput: with `out_ready` held at 1, one word per cycle, `NW` cycles per digest.
- With `out_ready` held at 1, `out_valid` drops in the cycle after the last handshake unless a back-to-back capture occurred.
- Minimum spacing between accepted digests is `NW` cycles.
- All outputs are registered or decoded only from registered state; no combinational path from `out_ready` or `hash_ready` to any output.

## Structure
- Shared hash package holds:
  - the default `l` (256);
  - the state encoding localparams `S_IDLE`/`S_STREAM`, shared with the other hash-side FSMs.
- One sub-module: `rise_detect` (1-bit registered edge detector, async active-low reset). It will be reused for other `ready` consumers.
- The shift register, counter and FSM stay inline.

## Test plan
- Word order and continuous drain:
  - Stimulus: reset, then pulse `hash_ready` with `hash_text` = 8 words 11111111,22222222,…,88888888 (MSW first); `out_ready`=1.
  - Response: `out_data` 11111111..88888888 on 8 consecutive cycles, `out_last` only on 88888888, then `busy`=0.
- Backpressure:
  - Stimulus: same digest, `out_ready` low for 3 cycles on word 2.
  - Response: `out_data`=33333333 stable for 4 cycles; all 8 words delivered, none lost or duplicated.
- Overrun drop:
  - Stimulus: second `hash_ready` rising edge at word 4 of the first digest.
  - Response: `overrun`=1 from the next cycle; words 5–8 of the first digest unchanged; no second stream. `clr_overrun` for one cycle then returns `overrun` to 0.
- Back-to-back:
  - Stimulus: rising edge of `hash_ready` coincident with the handshake of 88888888, new digest all AAAAAAAA.
  - Response: next cycle `out_data`=AAAAAAAA with `out_valid` never deasserted; `overrun` stays 0.
- Level hold and reset abort:
  - Stimulus: `hash_ready` held high for 20 cycles.
  - Response: exactly one digest is streamed.
  - Stimulus: `rst` low during word 3.
  - Response: all outputs 0 immediately. After release, with `hash_ready` still high, no capture occurs until the next rising edge.
